rca_32_bit: RTL and testbench
=============================

Name: rca_32_bit

Overview:
- 32-bit ripple-carry adder with registered outputs: s, c_out = a + b + c_in.
- Carry chain built from a cascade of 1-bit full adders, bit 0 to bit WIDTH-1; no lookahead.
- Result registered on the clock edge so the adder slots into a synchronous datapath as a single-cycle arithmetic stage.

Parameters:
- WIDTH, 32, operand and sum width in bits. 32 is the only width the block is verified at; the structure must still elaborate for any WIDTH >= 1.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous reset, active-high
- a      input   WIDTH  addend A, unsigned
- b      input   WIDTH  addend B, unsigned
- c_in   input   1      carry into bit 0
- s      output  WIDTH  registered sum, low WIDTH bits of a+b+c_in
- c_out  output  1      registered carry out of bit WIDTH-1

Behaviour:
- One clock: clk. Reset: rst is synchronous and active-high.
- Reset:
  - On a rising clk edge with rst=1: s <= 0 and c_out <= 0.
  - rst has priority over the add.
  - No asynchronous path.
  - Outputs are undefined only before the first clk edge; benches must apply reset first.
- Datapath:
  - Combinational ripple of WIDTH full adders.
  - Bit i: sum_i = a[i] ^ b[i] ^ carry_i; carry_{i+1} = (a[i]&b[i]) | (carry_i&(a[i]^b[i])).
  - carry_0 = c_in; c_out takes carry_WIDTH.
- Latency:
  - On each rising clk edge with rst=0, {c_out, s} <= a + b + c_in, using the inputs present at that edge.
  - Results are visible exactly 1 cycle after the inputs are sampled.
  - New inputs are accepted every cycle (throughput 1/cycle). No handshake, no enable.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - {c_out, s} is the exact (WIDTH+1)-bit sum. Maximum value is 2*(2^WIDTH-1)+1, which always fits.
  - No signed-overflow flag is produced.
- Wrap-around:
  - a=2^WIDTH-1, b=0, c_in=1 gives s=0, c_out=1.
  - a=b=2^WIDTH-1, c_in=1 gives s=2^WIDTH-1, c_out=1.
- Reset mid-operation: asserting rst on an edge discards the sum being captured on that edge; outputs read 0 the following cycle. Deasserting rst resumes normal capture on the next edge.
- Timing: the critical path is the full carry ripple, a[0]/c_in to c_out, and it must fit in one clk period. Inputs are not registered inside the block.

Decomposition:
- Shared package: WIDTH default constant (32) and a typedef for the WIDTH-bit word. No other shared types.
- One sub-module, full_adder: inputs a, b, cin; outputs sum, cout; purely combinational.
- Instantiate full_adder WIDTH times via generate, chaining cout to the next cin.
- The output register lives in the top module.

Test Plan:
- Reset: drive rst=1 for 2 cycles with a=5, b=7 -> s=0, c_out=0. Release rst -> next cycle s=12, c_out=0.
- Carry-in used: a=123456784, b=98765432, c_in=1 -> one cycle later s=222222217, c_out=0.
- No carry-in, back-to-back:
  - a=434893543, b=98765432, c_in=0 -> s=533658975, c_out=0.
  - Next cycle, a=543895434, b=45, c_in=1 -> s=543895480, c_out=0.
  - Confirm one result per cycle.
- Overflow:
  - a=4294967290, b=67, c_in=1 -> s=62, c_out=1.
  - a=0xFFFFFFFF, b=0, c_in=1 -> s=0, c_out=1 (full-length ripple).
- Max and zero operands:
  - a=b=0xFFFFFFFF, c_in=1 -> s=0xFFFFFFFF, c_out=1.
  - a=b=0, c_in=0 -> s=0, c_out=0.
- Reset mid-stream: stream random operands, assert rst for one edge -> that cycle's outputs are 0 and the sum is not captured; the following edge resumes correct sums. Check every cycle against the golden model {c_out, s} = a + b + c_in, delayed one cycle.

Source files
------------

// File: rtl/rca_32_bit_pkg.sv
// ---------------------------------------------------------------------------
// rca_32_bit_pkg
// Shared constants and types for the ripple-carry adder slice.
//   WIDTH_DEFAULT : default operand / sum width in bits (32)
//   word_t        : WIDTH_DEFAULT-bit unsigned word
// ---------------------------------------------------------------------------
package rca_32_bit_pkg;

   localparam int WIDTH_DEFAULT = 32;

   typedef logic [WIDTH_DEFAULT-1:0] word_t;

endpackage : rca_32_bit_pkg

// File: rtl/rca_32_bit_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit combinational full adder, the building block of the ripple chain.
// Ports:
//   a, b  : input  1  operand bits
//   cin   : input  1  carry in from the next-lower bit
//   sum   : output 1  a ^ b ^ cin
//   cout  : output 1  carry out to the next-higher bit
// ---------------------------------------------------------------------------
import rca_32_bit_pkg::*;

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic w_prop;

   // The propagate term is shared between the sum and the carry equations so
   // the carry is generated either locally (a & b) or passed through from cin.
   assign w_prop = a ^ b;
   assign sum    = w_prop ^ cin;
   assign cout   = (a & b) | (cin & w_prop);

endmodule : full_adder

// File: rtl/rca_32_bit.sv
// ---------------------------------------------------------------------------
// rca_32_bit
// WIDTH-bit ripple-carry adder with registered outputs: {c_out, s} = a+b+c_in.
// The carry ripples through WIDTH full adders from bit 0 upward; the result
// is captured on the rising clock edge, giving a single-cycle arithmetic
// stage with one result per cycle.
// Ports:
//   clk   : input  1      rising-edge clock
//   rst   : input  1      synchronous reset, active-high (clears s and c_out)
//   a     : input  WIDTH  addend A, unsigned
//   b     : input  WIDTH  addend B, unsigned
//   c_in  : input  1      carry into bit 0
//   s     : output WIDTH  registered sum, low WIDTH bits of a+b+c_in
//   c_out : output 1      registered carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
import rca_32_bit_pkg::*;

module rca_32_bit #(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] s,
   output logic             c_out
);

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   // The carry vector holds one entry per bit boundary: w_carry[i] enters
   // bit i and w_carry[WIDTH] is the carry out of the whole word.
   assign w_carry[0] = c_in;

   // Chain WIDTH full adders, each feeding its carry into the next stage.
   // Deliberately no lookahead: the critical path is the full ripple.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      full_adder u_fa (
         .a    (a[gi]),
         .b    (b[gi]),
         .cin  (w_carry[gi]),
         .sum  (w_sum[gi]),
         .cout (w_carry[gi+1])
      );
   end

   // Output register. Reset wins over the add, so a sum arriving on a reset
   // edge is dropped and the outputs read zero for the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else begin
         r_sum  <= w_sum;
         r_cout <= w_carry[WIDTH];
      end
   end

   assign s     = r_sum;
   assign c_out = r_cout;

endmodule : rca_32_bit

// File: tb/tb_rca_32_bit.sv
// ---------------------------------------------------------------------------
// tb_rca_32_bit
// Scoreboard bench for rca_32_bit. Each driven vector pushes its expected
// {c_out, s} into a queue; a monitor pops one entry per rising edge that has
// a pending vector and compares it against the registered outputs.
// ---------------------------------------------------------------------------
import rca_32_bit_pkg::*;

module tb_rca_32_bit;

   typedef struct {
      logic [WIDTH_DEFAULT:0] expSum;
      string                  name;
   } sbItem_t;

   logic  clk;
   logic  rst;
   word_t a;
   word_t b;
   logic  c_in;
   word_t s;
   logic  c_out;

   sbItem_t sbQueue[$];
   int      vectorCount = 0;
   int      missCount   = 0;

   rca_32_bit #(.WIDTH(WIDTH_DEFAULT)) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .s     (s),
      .c_out (c_out)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one vector on the falling edge so it is stable for the next rising
   // edge, and record what the outputs must read just after that edge.
   task automatic applyStimulus(input logic rstIn, input word_t aIn,
                                input word_t bIn, input logic cIn,
                                input logic [WIDTH_DEFAULT:0] expIn,
                                input string nameIn);
      sbItem_t item;
      @(negedge clk);
      rst  = rstIn;
      a    = aIn;
      b    = bIn;
      c_in = cIn;
      item.expSum = expIn;
      item.name   = nameIn;
      sbQueue.push_back(item);
   endtask

   // Compare the registered outputs with one scoreboard entry.
   task automatic checkOutput(input sbItem_t item);
      vectorCount++;
      if ({c_out, s} !== item.expSum) begin
         missCount++;
         $display("[TB] FAIL %s: got c_out=%0b s=%0d, expected c_out=%0b s=%0d",
                  item.name, c_out, s, item.expSum[WIDTH_DEFAULT],
                  item.expSum[WIDTH_DEFAULT-1:0]);
      end
   endtask

   // Monitor: every rising edge that has a pending vector produces exactly
   // one result, sampled 1 time unit after the edge.
   initial begin
      sbItem_t item;
      forever begin
         @(posedge clk);
         if (sbQueue.size() > 0) begin
            #1;
            item = sbQueue.pop_front();
            checkOutput(item);
         end
      end
   end

   // Directed vectors first, then a random stream with a one-edge reset.
   initial begin
      word_t ra;
      word_t rb;
      logic  rc;
      int    waitCycles;

      rst  = 1'b1;
      a    = '0;
      b    = '0;
      c_in = 1'b0;

      applyStimulus(1'b1, 32'd5, 32'd7, 1'b0, 33'd0, "reset_0");
      applyStimulus(1'b1, 32'd5, 32'd7, 1'b0, 33'd0, "reset_1");
      applyStimulus(1'b0, 32'd5, 32'd7, 1'b0, 33'd12, "release");

      applyStimulus(1'b0, 32'd123456784, 32'd98765432, 1'b1,
                    33'd222222217, "carry_in");
      applyStimulus(1'b0, 32'd434893543, 32'd98765432, 1'b0,
                    33'd533658975, "b2b_0");
      applyStimulus(1'b0, 32'd543895434, 32'd45, 1'b1,
                    33'd543895480, "b2b_1");

      applyStimulus(1'b0, 32'd4294967290, 32'd67, 1'b1,
                    {1'b1, 32'd62}, "overflow");
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1,
                    {1'b1, 32'd0}, "full_ripple");
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                    {1'b1, 32'hFFFF_FFFF}, "max_ops");
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 33'd0, "zero_ops");
      applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0,
                    {1'b1, 32'd0}, "msb_carry");

      // Random stream with reset asserted on exactly one edge (i == 6).
      for (int i = 0; i < 16; i++) begin
         ra = $urandom();
         rb = $urandom();
         rc = 1'($urandom_range(1, 0));
         if (i == 6)
            applyStimulus(1'b1, ra, rb, rc, 33'd0, "rand_rst");
         else
            applyStimulus(1'b0, ra, rb, rc,
                          {1'b0, ra} + {1'b0, rb} + {32'd0, rc}, "rand");
      end

      // Let the monitor drain the scoreboard, bounded in cycles.
      waitCycles = 0;
      while (sbQueue.size() > 0 && waitCycles < 10) begin
         @(posedge clk);
         waitCycles++;
      end
      #2;
      if (sbQueue.size() != 0) begin
         missCount++;
         $display("[TB] FAIL drain: got %0d pending entries, expected 0",
                  sbQueue.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectorCount, missCount);
      $finish;
   end

endmodule : tb_rca_32_bit
